// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter interface: requester-side result offers and the broadcast bus.
// Ports: fu_valid/fu_ready handshake with per-requester tag/value/take_branch/pc/npc slices,
//        and the registered cdb_* broadcast (valid, tag, value, take_branch, pc, npc, src).
// Modports: master = functional-unit side / consumer, slave = arbiter.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        fu_valid;
  logic [N_REQ-1:0]        fu_ready;
  logic [N_REQ*TAG_W-1:0]  fu_tag;
  logic [N_REQ*DATA_W-1:0] fu_value;
  logic [N_REQ-1:0]        fu_take_branch;
  logic [N_REQ*DATA_W-1:0] fu_pc;
  logic [N_REQ*DATA_W-1:0] fu_npc;

  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_value;
  logic                    cdb_take_branch;
  logic [DATA_W-1:0]       cdb_pc;
  logic [DATA_W-1:0]       cdb_npc;
  logic [SRC_W-1:0]        cdb_src;

  modport master (
    output fu_valid, fu_tag, fu_value, fu_take_branch, fu_pc, fu_npc,
    input  fu_ready,
    input  cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_pc, cdb_npc, cdb_src
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value, fu_take_branch, fu_pc, fu_npc,
    output fu_ready,
    output cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_pc, cdb_npc, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common data bus arbiter with one holding buffer per functional unit.
// Latency: accepted at edge E0, broadcast registered at E1 (visible the cycle after E1).
// Backpressure: fu_ready[i] low while buffer i is full and not granted, or during squash/reset.
// Ports: clock, reset (sync, active-high), squash (flush), bus (cdb_arbiter_if.slave).
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(N_REQ);

  // Holding buffers
  logic [N_REQ-1:0]  buf_valid;
  logic [TAG_W-1:0]  buf_tag         [N_REQ];
  logic [DATA_W-1:0] buf_value       [N_REQ];
  logic [DATA_W-1:0] buf_pc          [N_REQ];
  logic [DATA_W-1:0] buf_npc         [N_REQ];
  logic [N_REQ-1:0]  buf_take_branch;

  logic [SRC_W-1:0]  rr_ptr;
  logic              gnt_any;
  logic [SRC_W-1:0]  gnt_idx;
  logic [SRC_W-1:0]  rr_next;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;

  // Registered broadcast
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_value_q;
  logic              cdb_take_branch_q;
  logic [DATA_W-1:0] cdb_pc_q;
  logic [DATA_W-1:0] cdb_npc_q;
  logic [SRC_W-1:0]  cdb_src_q;

  // First valid buffer at or after rr_ptr, wrapping modulo N_REQ. The explicit
  // subtract keeps the wrap correct when N_REQ is not a power of two.
  always_comb begin : arbitrate
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && buf_valid[SRC_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  assign grant   = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  assign rr_next = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // A granted buffer drains at this edge, so it can take a new result in the same cycle.
  assign bus.fu_ready = (reset || squash) ? '0 : (~buf_valid | grant);
  assign accept       = bus.fu_valid & bus.fu_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid         <= '0;
      rr_ptr            <= '0;
      cdb_valid_q       <= 1'b0;
      cdb_tag_q         <= '0;
      cdb_value_q       <= '0;
      cdb_take_branch_q <= 1'b0;
      cdb_pc_q          <= '0;
      cdb_npc_q         <= '0;
      cdb_src_q         <= '0;
    end else if (squash) begin
      // Payload fields of cdb_* hold; only validity is dropped.
      buf_valid   <= '0;
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          buf_valid[i]       <= 1'b1;
          buf_tag[i]         <= bus.fu_tag[i*TAG_W +: TAG_W];
          buf_value[i]       <= bus.fu_value[i*DATA_W +: DATA_W];
          buf_pc[i]          <= bus.fu_pc[i*DATA_W +: DATA_W];
          buf_npc[i]         <= bus.fu_npc[i*DATA_W +: DATA_W];
          buf_take_branch[i] <= bus.fu_take_branch[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (gnt_any) begin
        cdb_valid_q       <= 1'b1;
        cdb_tag_q         <= buf_tag[gnt_idx];
        cdb_value_q       <= buf_value[gnt_idx];
        cdb_take_branch_q <= buf_take_branch[gnt_idx];
        cdb_pc_q          <= buf_pc[gnt_idx];
        cdb_npc_q         <= buf_npc[gnt_idx];
        cdb_src_q         <= gnt_idx;
        rr_ptr            <= rr_next;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid       = cdb_valid_q;
  assign bus.cdb_tag         = cdb_tag_q;
  assign bus.cdb_value       = cdb_value_q;
  assign bus.cdb_take_branch = cdb_take_branch_q;
  assign bus.cdb_pc          = cdb_pc_q;
  assign bus.cdb_npc         = cdb_npc_q;
  assign bus.cdb_src         = cdb_src_q;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of functional-unit requesters, legal range 2..8.
REQ-002 Parameter TAG_W, default 5: ROB tag width, so the ROB holds 32 entries.
REQ-003 Parameter DATA_W, default 32: width of the value, PC and NPC fields.
REQ-004 reset is synchronous and active-high; clock is clock.
REQ-005 Ports (name, direction, width, meaning):
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- squash, in, 1, flush request; all in-flight results are discarded.
- fu_valid, in, N_REQ, result offered by requester i.
- fu_ready, out, N_REQ, requester i result accepted this cycle.
- fu_tag, in, N_REQ*TAG_W, ROB tags; slice i belongs to requester i.
- fu_value, in, N_REQ*DATA_W, result values.
- fu_take_branch, in, N_REQ, branch-taken flags.
- fu_pc, in, N_REQ*DATA_W, instruction PCs.
- fu_npc, in, N_REQ*DATA_W, next PCs.
- cdb_valid, out, 1, broadcast valid.
- cdb_tag, out, TAG_W, broadcast ROB tag.
- cdb_value, out, DATA_W, broadcast value.
- cdb_take_branch, out, 1, broadcast branch-taken flag.
- cdb_pc, out, DATA_W, broadcast PC.
- cdb_npc, out, DATA_W, broadcast next PC.
- cdb_src, out, clog2(N_REQ), index of the broadcasting requester.

Function
REQ-006 One holding buffer per requester: buf_valid[i] plus the tag/value/take_branch/pc/npc fields.
REQ-007 fu_ready[i] = !squash && (!buf_valid[i] || grant[i]), combinational.
REQ-008 Acceptance happens when fu_valid[i] && fu_ready[i] at a rising edge; the buffer loads the inputs and buf_valid[i] becomes 1.
REQ-009 When a buffer is granted and not reloaded in the same cycle, buf_valid[i] clears at the edge.
REQ-010 When a buffer is granted and reloaded in the same cycle, it holds the new result with buf_valid[i]=1.
REQ-011 Arbitration considers buffered entries only; raw fu_* inputs never reach the CDB directly.
REQ-012 At most one grant per cycle.
REQ-013 Grant selection: the first i with buf_valid[i] set, searching upward from rr_ptr and wrapping modulo N_REQ.
REQ-014 rr_ptr register width is clog2(N_REQ).
- On a grant to g, rr_ptr <= (g+1) mod N_REQ.
- With no grant, rr_ptr holds.
- The wrap is correct for N_REQ that is not a power of two.
REQ-015 The cdb_* outputs are registered: the granted buffer contents and index load at the edge, and cdb_valid <= 1.
REQ-016 With no grant, cdb_valid <= 0 and the other cdb_* fields hold their previous values.
REQ-017 Minimum latency: a result accepted at edge E0 appears on the CDB in the cycle after edge E1 (two edges), when uncontested.
REQ-018 Throughput: one broadcast per cycle sustained while any buffer is valid.
- A requester that is continuously valid and uncontested gets a broadcast every cycle.
REQ-019 Fairness: a pending buffer is granted within N_REQ cycles of becoming valid.
REQ-020 Squash at an edge clears all buf_valid, clears cdb_valid and sets rr_ptr to 0.
- fu_ready is 0 during the squash cycle.
- Offered inputs are not accepted and not lost silently; the requester keeps them.
REQ-021 Squash has priority over grant, acceptance and pointer update in the same cycle.

Reset
REQ-022 At a reset edge: all buf_valid = 0, rr_ptr = 0, cdb_valid = 0, cdb_tag/value/take_branch/pc/npc/src = 0.
REQ-023 fu_ready is 0 while reset is high.
REQ-024 fu_ready is all-ones in the first cycle after reset deasserts, since all buffers are empty.
REQ-025 Reset asserted mid-operation discards all buffered results, identical to REQ-022; reset has priority over squash.

Verification
REQ-026 Single request: fu_valid[2]=1 for one cycle, tag=7, value=0xDEADBEEF.
- Response: two edges later cdb_valid=1, cdb_tag=7, cdb_value=0xDEADBEEF, cdb_src=2 for exactly one cycle.
- Then rr_ptr=3.
REQ-027 Contention: all 4 buffers loaded in the same cycle, rr_ptr=0.
- Response: cdb_src sequence 0,1,2,3 on consecutive cycles, then cdb_valid=0.
- fu_ready[i] high in the cycle after each grant.
REQ-028 Back-to-back: requester 1 holds fu_valid=1 with new tags 1,2,3 every cycle, with no other requesters.
- Response: cdb_tag sequence 1,2,3 on consecutive cycles.
- fu_ready[1] stays 1 throughout.
REQ-029 Wrap, N_REQ=3: rr_ptr=2, buffers 0 and 2 valid.
- Response: grant to 2, then 0.
- rr_ptr follows 0 then 1.
REQ-030 Squash mid-operation: 3 buffers valid, squash=1 for one cycle.
- Response: fu_ready=0 in that cycle.
- Next cycle: cdb_valid=0, buffers empty, rr_ptr=0, and no stale tag is ever broadcast.
REQ-031 Reset during contention: 4 buffers valid, reset=1.
- Response: all outputs 0 next cycle, fu_ready=0 while reset is high and all-ones after.
